// File: rtl/hpm_counter_bank.sv
// Hardware performance monitor bank: run-time event mapping per counter, wrap/saturate
// counting, sticky overflow flags and a combined overflow interrupt behind a small CSR window.
module hpm_counter_bank #(
    parameter int NUM_COUNTERS = 8,
    parameter int NUM_EVENTS   = 16,
    parameter int CNT_WIDTH    = 64,
    parameter int INC_WIDTH    = 2,
    parameter int XLEN         = 64,
    localparam int SEL_W       = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             debug_mode_i,
    input  logic [NUM_EVENTS*INC_WIDTH-1:0]  event_inc_i,
    input  logic [SEL_W-1:0]                 sel_i,
    input  logic [1:0]                       field_i,
    input  logic                             we_i,
    input  logic [XLEN-1:0]                  wdata_i,
    output logic [XLEN-1:0]                  rdata_o,
    output logic [NUM_COUNTERS-1:0]          ovf_o,
    output logic                             irq_o
);

    localparam bit HAS_HI = (CNT_WIDTH > XLEN);
    localparam int LO_W   = HAS_HI ? XLEN : CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LO_MASK = {CNT_WIDTH{1'b1}} >> (CNT_WIDTH - LO_W);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0]    cnt_r     [NUM_COUNTERS];
    logic [7:0]              evsel_r   [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] inh_r;
    logic [NUM_COUNTERS-1:0] sat_r;
    logic [NUM_COUNTERS-1:0] irqen_r;
    logic [NUM_COUNTERS-1:0] ovf_r;

    logic [CNT_WIDTH-1:0]    cnt_d_s   [NUM_COUNTERS];
    logic [7:0]              evsel_d_s [NUM_COUNTERS];
    logic [INC_WIDTH-1:0]    inc_s     [NUM_COUNTERS];
    logic [CNT_WIDTH:0]      sum_s     [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] hit_s;
    logic [NUM_COUNTERS-1:0] ctrl_wr_s;
    logic [NUM_COUNTERS-1:0] ovf_set_s;
    logic [NUM_COUNTERS-1:0] inh_d_s;
    logic [NUM_COUNTERS-1:0] sat_d_s;
    logic [NUM_COUNTERS-1:0] irqen_d_s;
    logic [NUM_COUNTERS-1:0] ovf_d_s;

    // Next-state for every counter: CSR write takes priority and drops that cycle's increment.
    always_comb begin
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            hit_s[i]     = we_i && (sel_i == SEL_W'(i));
            ctrl_wr_s[i] = hit_s[i] && (field_i == 2'd3);
            inc_s[i]     = '0;
            // Out-of-range selects match no event and therefore add nothing.
            for (int e = 0; e < NUM_EVENTS; e++) begin
                inc_s[i] = (evsel_r[i] == 8'(e + 1)) ? event_inc_i[e*INC_WIDTH +: INC_WIDTH] : inc_s[i];
            end
            sum_s[i]     = {1'b0, cnt_r[i]} + (CNT_WIDTH + 1)'(inc_s[i]);
            cnt_d_s[i]   = cnt_r[i];
            ovf_set_s[i] = 1'b0;
            if (hit_s[i] && (field_i == 2'd0)) begin
                cnt_d_s[i] = (cnt_r[i] & ~LO_MASK) | (CNT_WIDTH'(wdata_i) & LO_MASK);
            end else if (hit_s[i] && (field_i == 2'd1) && HAS_HI) begin
                cnt_d_s[i] = (cnt_r[i] & LO_MASK) | ((CNT_WIDTH'(wdata_i) << XLEN) & ~LO_MASK);
            end else if (!debug_mode_i && !inh_r[i]) begin
                if (sat_r[i] && sum_s[i][CNT_WIDTH]) begin
                    cnt_d_s[i]   = CNT_MAX;
                    // A counter already pinned at all-ones does not re-flag overflow.
                    ovf_set_s[i] = (cnt_r[i] != CNT_MAX);
                end else begin
                    cnt_d_s[i]   = sum_s[i][CNT_WIDTH-1:0];
                    ovf_set_s[i] = sum_s[i][CNT_WIDTH];
                end
            end else begin
                cnt_d_s[i] = cnt_r[i];
            end
            evsel_d_s[i] = (hit_s[i] && (field_i == 2'd2)) ? wdata_i[7:0] : evsel_r[i];
            inh_d_s[i]   = ctrl_wr_s[i] ? wdata_i[0] : inh_r[i];
            sat_d_s[i]   = ctrl_wr_s[i] ? wdata_i[1] : sat_r[i];
            irqen_d_s[i] = ctrl_wr_s[i] ? wdata_i[2] : irqen_r[i];
            ovf_d_s[i]   = (ovf_r[i] & ~(ctrl_wr_s[i] & wdata_i[3])) | ovf_set_s[i];
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_r[i]   <= '0;
                evsel_r[i] <= 8'h00;
            end
            inh_r   <= '0;
            sat_r   <= '0;
            irqen_r <= '0;
            ovf_r   <= '0;
        end else begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_r[i]   <= cnt_d_s[i];
                evsel_r[i] <= evsel_d_s[i];
            end
            inh_r   <= inh_d_s;
            sat_r   <= sat_d_s;
            irqen_r <= irqen_d_s;
            ovf_r   <= ovf_d_s;
        end
    end

    // Side-effect-free CSR read mux; unmatched selects read zero.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (sel_i == SEL_W'(i)) begin
                case (field_i)
                    2'd0:    rdata_o = XLEN'(cnt_r[i]);
                    2'd1:    rdata_o = HAS_HI ? XLEN'(cnt_r[i] >> XLEN) : '0;
                    2'd2:    rdata_o = XLEN'(evsel_r[i]);
                    2'd3:    rdata_o = XLEN'({ovf_r[i], irqen_r[i], sat_r[i], inh_r[i]});
                    default: rdata_o = '0;
                endcase
            end else begin
                rdata_o = rdata_o;
            end
        end
    end

    assign ovf_o = ovf_r;
    assign irq_o = |(ovf_r & irqen_r);

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Directed bench for hpm_counter_bank: a default build, an 8-bit counter build and an
// XLEN=32 / 48-bit counter build, all sharing clock, reset and debug freeze.
module tb_hpm_counter_bank;

    logic clk;
    logic rst_n;
    logic dbg;

    logic [31:0] a_ev;
    logic [2:0]  a_sel;
    logic [1:0]  a_field;
    logic        a_we;
    logic [63:0] a_wdata;
    logic [63:0] a_rdata;
    logic [7:0]  a_ovf;
    logic        a_irq;

    logic [7:0]  b_ev;
    logic [1:0]  b_sel;
    logic [1:0]  b_field;
    logic        b_we;
    logic [63:0] b_wdata;
    logic [63:0] b_rdata;
    logic [2:0]  b_ovf;
    logic        b_irq;

    logic [7:0]  c_ev;
    logic [0:0]  c_sel;
    logic [1:0]  c_field;
    logic        c_we;
    logic [31:0] c_wdata;
    logic [31:0] c_rdata;
    logic [1:0]  c_ovf;
    logic        c_irq;

    int n_checks = 0;
    int n_fail   = 0;

    hpm_counter_bank dut_a (
        .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(dbg), .event_inc_i(a_ev),
        .sel_i(a_sel), .field_i(a_field), .we_i(a_we), .wdata_i(a_wdata),
        .rdata_o(a_rdata), .ovf_o(a_ovf), .irq_o(a_irq)
    );

    hpm_counter_bank #(.NUM_COUNTERS(3), .NUM_EVENTS(4), .CNT_WIDTH(8), .INC_WIDTH(2), .XLEN(64)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(dbg), .event_inc_i(b_ev),
        .sel_i(b_sel), .field_i(b_field), .we_i(b_we), .wdata_i(b_wdata),
        .rdata_o(b_rdata), .ovf_o(b_ovf), .irq_o(b_irq)
    );

    hpm_counter_bank #(.NUM_COUNTERS(2), .NUM_EVENTS(4), .CNT_WIDTH(48), .INC_WIDTH(2), .XLEN(32)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(dbg), .event_inc_i(c_ev),
        .sel_i(c_sel), .field_i(c_field), .we_i(c_we), .wdata_i(c_wdata),
        .rdata_o(c_rdata), .ovf_o(c_ovf), .irq_o(c_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [2:0] s, input logic [1:0] f, input logic [63:0] d);
        a_sel = s; a_field = f; a_wdata = d; a_we = 1'b1;
        tick();
        a_we = 1'b0;
    endtask

    task automatic wr_b(input logic [1:0] s, input logic [1:0] f, input logic [63:0] d);
        b_sel = s; b_field = f; b_wdata = d; b_we = 1'b1;
        tick();
        b_we = 1'b0;
    endtask

    task automatic wr_c(input logic [0:0] s, input logic [1:0] f, input logic [31:0] d);
        c_sel = s; c_field = f; c_wdata = d; c_we = 1'b1;
        tick();
        c_we = 1'b0;
    endtask

    task automatic chk_a(input string tag, input logic [2:0] s, input logic [1:0] f, input logic [63:0] exp);
        a_sel = s; a_field = f;
        #1;
        check_eq(tag, a_rdata, exp);
    endtask

    task automatic chk_b(input string tag, input logic [1:0] s, input logic [1:0] f, input logic [63:0] exp);
        b_sel = s; b_field = f;
        #1;
        check_eq(tag, b_rdata, exp);
    endtask

    task automatic chk_c(input string tag, input logic [0:0] s, input logic [1:0] f, input logic [63:0] exp);
        c_sel = s; c_field = f;
        #1;
        check_eq(tag, c_rdata, exp);
    endtask

    initial begin
        rst_n = 1'b0; dbg = 1'b0;
        a_ev = 32'h0; a_sel = 3'd0; a_field = 2'd0; a_we = 1'b0; a_wdata = 64'h0;
        b_ev = 8'h0;  b_sel = 2'd0; b_field = 2'd0; b_we = 1'b0; b_wdata = 64'h0;
        c_ev = 8'h0;  c_sel = 1'b0; c_field = 2'd0; c_we = 1'b0; c_wdata = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        for (int s = 0; s < 8; s++) begin
            for (int f = 0; f < 4; f++) begin
                chk_a("rst_a_rd", 3'(s), 2'(f), 64'h0);
            end
        end
        check_eq("rst_a_ovf", 64'(a_ovf), 64'h0);
        check_eq("rst_a_irq", 64'(a_irq), 64'h0);
        chk_b("rst_b_rd", 2'd2, 2'd3, 64'h0);
        chk_c("rst_c_rd", 1'b1, 2'd1, 64'h0);
        check_eq("rst_b_ovf", 64'(b_ovf), 64'h0);

        // Event-select boundaries: 16 maps to the last event, 17 disables
        wr_a(3'd3, 2'd2, 64'd17);
        wr_a(3'd4, 2'd2, 64'd16);
        a_ev = 32'h5555_5555;
        tick();
        tick();
        a_ev = 32'h0;
        chk_a("evsel_over", 3'd3, 2'd0, 64'd0);
        chk_a("evsel_last", 3'd4, 2'd0, 64'd2);

        // Counter0 and counter2 both on event 2, +3 per cycle for 10 cycles
        wr_a(3'd0, 2'd2, 64'd3);
        wr_a(3'd2, 2'd2, 64'd3);
        a_ev = 32'h30;
        tick();
        chk_a("latency_1cyc", 3'd0, 2'd0, 64'd3);
        for (int k = 0; k < 9; k++) tick();
        a_ev = 32'h0;
        chk_a("cnt0_30", 3'd0, 2'd0, 64'd30);
        chk_a("cnt0_hi", 3'd0, 2'd1, 64'd0);
        chk_a("cnt2_shared", 3'd2, 2'd0, 64'd30);
        chk_a("cnt1_disabled", 3'd1, 2'd0, 64'd0);
        chk_a("cnt4_idle", 3'd4, 2'd0, 64'd2);

        // Inhibit on counter0 only
        wr_a(3'd0, 2'd3, 64'h1);
        a_ev = 32'h30;
        tick();
        tick();
        a_ev = 32'h0;
        chk_a("inhibit_hold", 3'd0, 2'd0, 64'd30);
        chk_a("inhibit_ctrl", 3'd0, 2'd3, 64'h1);
        chk_a("cnt2_after_inh", 3'd2, 2'd0, 64'd36);

        // Debug freeze; CSR writes still land
        dbg = 1'b1;
        a_ev = 32'h30;
        tick();
        tick();
        tick();
        a_ev = 32'h0;
        chk_a("debug_freeze", 3'd2, 2'd0, 64'd36);
        wr_a(3'd2, 2'd0, 64'd5);
        chk_a("debug_write", 3'd2, 2'd0, 64'd5);
        dbg = 1'b0;

        // Same-cycle write and increment on counter0
        wr_a(3'd0, 2'd3, 64'h0);
        a_ev = 32'h20;
        wr_a(3'd0, 2'd0, 64'h100);
        a_ev = 32'h0;
        chk_a("wr_vs_inc", 3'd0, 2'd0, 64'h100);
        chk_a("wr_vs_inc_other", 3'd2, 2'd0, 64'd7);
        check_eq("wr_vs_inc_ovf", 64'(a_ovf), 64'h0);
        wr_a(3'd1, 2'd1, 64'hDEAD);
        chk_a("hi_absent_rd", 3'd1, 2'd1, 64'h0);
        chk_a("hi_absent_lo", 3'd1, 2'd0, 64'h0);

        // 8-bit wrap: 0xFE + 3 -> 0x01 with overflow and interrupt
        wr_b(2'd0, 2'd2, 64'd1);
        wr_b(2'd0, 2'd3, 64'h4);
        wr_b(2'd0, 2'd0, 64'hFE);
        b_ev = 8'h03;
        tick();
        b_ev = 8'h00;
        chk_b("wrap_cnt", 2'd0, 2'd0, 64'h01);
        check_eq("wrap_ovf", 64'(b_ovf), 64'h1);
        check_eq("wrap_irq", 64'(b_irq), 64'h1);
        chk_b("wrap_ctrl", 2'd0, 2'd3, 64'hC);
        wr_b(2'd0, 2'd3, 64'hC);
        check_eq("w1c_ovf", 64'(b_ovf), 64'h0);
        check_eq("w1c_irq", 64'(b_irq), 64'h0);
        chk_b("w1c_ctrl", 2'd0, 2'd3, 64'h4);

        // 8-bit saturate on counter1
        wr_b(2'd0, 2'd3, 64'h1);
        wr_b(2'd1, 2'd2, 64'd1);
        wr_b(2'd1, 2'd3, 64'h2);
        wr_b(2'd1, 2'd0, 64'hFE);
        b_ev = 8'h03;
        tick();
        b_ev = 8'h00;
        chk_b("sat_cnt", 2'd1, 2'd0, 64'hFF);
        check_eq("sat_ovf", 64'(b_ovf), 64'h2);
        check_eq("sat_irq_off", 64'(b_irq), 64'h0);
        wr_b(2'd1, 2'd3, 64'hA);
        b_ev = 8'h01;
        tick();
        b_ev = 8'h00;
        chk_b("sat_stay", 2'd1, 2'd0, 64'hFF);
        check_eq("sat_no_reovf", 64'(b_ovf), 64'h0);
        chk_b("inh_b0", 2'd0, 2'd0, 64'h01);

        // Overflow set beats a same-cycle W1C
        wr_b(2'd2, 2'd2, 64'd1);
        wr_b(2'd2, 2'd0, 64'hFF);
        b_ev = 8'h01;
        wr_b(2'd2, 2'd3, 64'h8);
        b_ev = 8'h00;
        chk_b("set_wins_cnt", 2'd2, 2'd0, 64'h00);
        check_eq("set_wins_ovf", 64'(b_ovf), 64'h4);

        // Out-of-range select and 8-bit event-select storage
        wr_b(2'd3, 2'd0, 64'h55);
        chk_b("oor_read", 2'd3, 2'd0, 64'h0);
        chk_b("oor_nowrite", 2'd2, 2'd0, 64'h0);
        wr_b(2'd2, 2'd2, 64'h1FF);
        chk_b("evsel_8bit", 2'd2, 2'd2, 64'hFF);

        // XLEN=32, 48-bit counter crossing the 32-bit boundary
        wr_c(1'b0, 2'd2, 32'd1);
        wr_c(1'b0, 2'd0, 32'hFFFF_FFFE);
        c_ev = 8'h03;
        tick();
        c_ev = 8'h00;
        chk_c("carry_lo", 1'b0, 2'd0, 64'h1);
        chk_c("carry_hi", 1'b0, 2'd1, 64'h1);
        check_eq("carry_no_ovf", 64'(c_ovf), 64'h0);
        wr_c(1'b0, 2'd1, 32'h1234_ABCD);
        chk_c("hi_trunc", 1'b0, 2'd1, 64'hABCD);
        chk_c("hi_keeps_lo", 1'b0, 2'd0, 64'h1);

        // Reset asserted mid-burst
        wr_c(1'b1, 2'd2, 32'd1);
        c_ev = 8'h03;
        a_ev = 32'h30;
        tick();
        tick();
        chk_c("burst_cnt", 1'b1, 2'd0, 64'd6);
        #1;
        rst_n = 1'b0;
        chk_c("arst_c0_lo", 1'b0, 2'd0, 64'h0);
        chk_c("arst_c0_hi", 1'b0, 2'd1, 64'h0);
        chk_c("arst_c1", 1'b1, 2'd0, 64'h0);
        chk_a("arst_a2", 3'd2, 2'd0, 64'h0);
        check_eq("arst_b_ovf", 64'(b_ovf), 64'h0);
        tick();
        rst_n = 1'b1;
        wr_c(1'b0, 2'd2, 32'd1);
        chk_c("post_rst_nocount", 1'b0, 2'd0, 64'h0);
        tick();
        chk_c("post_rst_first", 1'b0, 2'd0, 64'd3);
        c_ev = 8'h00;
        a_ev = 32'h0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
